multicycle_ctrl: RTL

Multicycle control unit for the 16-bit, 4-bit-opcode CPU. It sequences fetch, decode, execute, memory and writeback over several clocks, drives the datapath enables and mux selects each cycle, and handshakes with a shared single-port memory that may take a variable number of cycles. It also counts retired instructions and stops on `halt` or an illegal opcode.

---
 rtl/ctrl_pkg.sv | 88 ++++++++
 rtl/multicycle_ctrl_outdec.sv | 101 ++++++++++
 rtl/multicycle_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg
// Shared encodings for the multicycle CPU control unit and its datapath:
// opcode and FSM state enums, mux-select / ALU-op localparams, and the
// bundled control-strobe struct produced by the output decoder.
// ---------------------------------------------------------------------------
package ctrl_pkg;

    typedef enum logic [3:0] {
        OP_RTYPE = 4'h0,
        OP_ADDI  = 4'h1,
        OP_LW    = 4'h2,
        OP_SW    = 4'h3,
        OP_BEQ   = 4'h4,
        OP_J     = 4'h5,
        OP_JAL   = 4'h6,
        OP_JR    = 4'h7,
        OP_HALT  = 4'hF
    } opcode_e;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_ALUWB,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_BRANCH,
        S_JUMP,
        S_JAL,
        S_JR,
        S_HALT
    } state_e;

    // aluCtrl
    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [2:0] ALU_AND   = 3'd2;
    localparam logic [2:0] ALU_OR    = 3'd3;
    localparam logic [2:0] ALU_SLT   = 3'd4;
    localparam logic [2:0] ALU_FUNCT = 3'd5;

    // pcSrc
    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;
    localparam logic [1:0] PCSRC_RS     = 2'd3;

    // regDst
    localparam logic [1:0] REGDST_RT   = 2'd0;
    localparam logic [1:0] REGDST_RD   = 2'd1;
    localparam logic [1:0] REGDST_LINK = 2'd2;

    // memToReg
    localparam logic [1:0] M2R_ALUOUT = 2'd0;
    localparam logic [1:0] M2R_MDR    = 2'd1;
    localparam logic [1:0] M2R_PC     = 2'd2;

    // aluSrcA / aluSrcB
    localparam logic       ALUA_PC  = 1'b0;
    localparam logic       ALUA_RS  = 1'b1;
    localparam logic [1:0] ALUB_RT  = 2'd0;
    localparam logic [1:0] ALUB_TWO = 2'd1;
    localparam logic [1:0] ALUB_IMM = 2'd2;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       i_or_d;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_ctrl;
    } ctrl_out_t;

    function automatic logic is_mem_state(state_e s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_outdec.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_outdec
// Combinational map from the current FSM state to the datapath strobes.
//   i_state     : current control state
//   i_op        : IR opcode field (selects R-type vs addi variants)
//   i_zero      : ALU zero flag (branch decision)
//   i_mem_ready : memory completes the access this cycle
//   o_ctrl      : bundled control strobes / mux selects
// ---------------------------------------------------------------------------
module multicycle_ctrl_outdec
    import ctrl_pkg::*;
(
    input  state_e      i_state,
    input  logic [3:0]  i_op,
    input  logic        i_zero,
    input  logic        i_mem_ready,
    output ctrl_out_t   o_ctrl
);

    always_comb begin
        o_ctrl = '0;
        case (i_state)
            S_FETCH: begin
                o_ctrl.mem_req   = 1'b1;
                o_ctrl.i_or_d    = 1'b0;
                // IR and PC load only on the completing cycle so wait cycles
                // do not advance the PC more than once.
                o_ctrl.ir_write  = i_mem_ready;
                o_ctrl.pc_write  = i_mem_ready;
                o_ctrl.pc_src    = PCSRC_ALU;
                o_ctrl.alu_src_a = ALUA_PC;
                o_ctrl.alu_src_b = ALUB_TWO;
                o_ctrl.alu_ctrl  = ALU_ADD;
            end
            S_DECODE: begin
                // Branch target PC + imm precomputed into ALUOut.
                o_ctrl.alu_src_a = ALUA_PC;
                o_ctrl.alu_src_b = ALUB_IMM;
                o_ctrl.alu_ctrl  = ALU_ADD;
            end
            S_EXEC: begin
                o_ctrl.alu_src_a = ALUA_RS;
                if (i_op == OP_RTYPE) begin
                    o_ctrl.alu_src_b = ALUB_RT;
                    o_ctrl.alu_ctrl  = ALU_FUNCT;
                end else begin
                    o_ctrl.alu_src_b = ALUB_IMM;
                    o_ctrl.alu_ctrl  = ALU_ADD;
                end
            end
            S_ALUWB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.mem_to_reg = M2R_ALUOUT;
                o_ctrl.reg_dst    = (i_op == OP_RTYPE) ? REGDST_RD : REGDST_RT;
            end
            S_MEMADR: begin
                o_ctrl.alu_src_a = ALUA_RS;
                o_ctrl.alu_src_b = ALUB_IMM;
                o_ctrl.alu_ctrl  = ALU_ADD;
            end
            S_MEMRD: begin
                o_ctrl.mem_req = 1'b1;
                o_ctrl.i_or_d  = 1'b1;
            end
            S_MEMWB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.mem_to_reg = M2R_MDR;
                o_ctrl.reg_dst    = REGDST_RT;
            end
            S_MEMWR: begin
                o_ctrl.mem_req = 1'b1;
                o_ctrl.mem_we  = 1'b1;
                o_ctrl.i_or_d  = 1'b1;
            end
            S_BRANCH: begin
                o_ctrl.alu_src_a = ALUA_RS;
                o_ctrl.alu_src_b = ALUB_RT;
                o_ctrl.alu_ctrl  = ALU_SUB;
                o_ctrl.pc_write  = i_zero;
                o_ctrl.pc_src    = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                o_ctrl.pc_write = 1'b1;
                o_ctrl.pc_src   = PCSRC_JUMP;
            end
            S_JAL: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.reg_dst    = REGDST_LINK;
                o_ctrl.mem_to_reg = M2R_PC;
                o_ctrl.pc_write   = 1'b1;
                o_ctrl.pc_src     = PCSRC_JUMP;
            end
            S_JR: begin
                o_ctrl.pc_write = 1'b1;
                o_ctrl.pc_src   = PCSRC_RS;
            end
            default: o_ctrl = '0; // IDLE, HALT
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
// Control unit for the 16-bit multicycle CPU. Sequences fetch / decode /
// execute / memory / writeback, handshakes with a variable-latency memory,
// counts retired instructions, and stops on halt, illegal opcode or memory
// timeout.
//   clk, reset      : clock, synchronous active-low reset
//   op, zero        : IR opcode, ALU zero flag
//   memReady        : memory completes current access
//   memReq..aluCtrl : datapath strobes and mux selects
//   halted, error   : sticky stop / fault flags
//   instret         : retired-instruction counter (wraps)
// ---------------------------------------------------------------------------
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
)(
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  op,
    input  logic        zero,
    input  logic        memReady,
    output logic        memReq,
    output logic        memWe,
    output logic        iOrD,
    output logic        irWrite,
    output logic        pcWrite,
    output logic [1:0]  pcSrc,
    output logic        regWrite,
    output logic [1:0]  regDst,
    output logic [1:0]  memToReg,
    output logic        aluSrcA,
    output logic [1:0]  aluSrcB,
    output logic [2:0]  aluCtrl,
    output logic        halted,
    output logic        error,
    output logic [15:0] instret
);

    // Last wait count before the access is abandoned.
    localparam logic [7:0] LP_WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_e      r_state;
    state_e      w_next;
    logic [7:0]  r_wait;
    logic [15:0] r_instret;
    logic        r_halted;
    logic        r_error;
    logic        w_mem_state;
    logic        w_timeout;
    logic        w_err_halt;
    logic        w_retire;
    ctrl_out_t   w_out;

    assign w_mem_state = is_mem_state(r_state);
    assign w_timeout   = w_mem_state && !memReady && (r_wait == LP_WAIT_LAST);

    // State register plus the counters that advance with it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_wait    <= 8'd0;
            r_instret <= 16'd0;
            r_halted  <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_state <= w_next;
            // Counter is zero whenever a memory state is entered, since it
            // is cleared in every non-waiting cycle.
            r_wait  <= (w_mem_state && !memReady && !w_timeout) ? r_wait + 8'd1 : 8'd0;
            if (w_retire)
                r_instret <= r_instret + 16'd1;
            if (w_next == S_HALT)
                r_halted <= 1'b1;
            if (w_err_halt)
                r_error <= 1'b1;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next     = r_state;
        w_err_halt = 1'b0;
        case (r_state)
            S_IDLE:   w_next = S_FETCH;
            S_FETCH:  if (memReady) w_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_RTYPE, OP_ADDI: w_next = S_EXEC;
                    OP_LW, OP_SW:      w_next = S_MEMADR;
                    OP_BEQ:            w_next = S_BRANCH;
                    OP_J:              w_next = S_JUMP;
                    OP_JAL:            w_next = S_JAL;
                    OP_JR:             w_next = S_JR;
                    OP_HALT:           w_next = S_HALT;
                    default: begin
                        w_next     = S_HALT;
                        w_err_halt = 1'b1;
                    end
                endcase
            end
            S_EXEC:   w_next = S_ALUWB;
            S_ALUWB:  w_next = S_FETCH;
            S_MEMADR: w_next = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (memReady) w_next = S_MEMWB;
            S_MEMWB:  w_next = S_FETCH;
            S_MEMWR:  if (memReady) w_next = S_FETCH;
            S_BRANCH, S_JUMP, S_JAL, S_JR: w_next = S_FETCH;
            S_HALT:   w_next = S_HALT;
            default:  w_next = S_IDLE;
        endcase
        if (w_timeout) begin
            w_next     = S_HALT;
            w_err_halt = 1'b1;
        end
    end

    // Retirement: last cycle of each instruction; halt opcode retires at
    // decode, illegal opcodes and timeouts never do.
    always_comb begin
        w_retire = 1'b0;
        case (r_state)
            S_ALUWB, S_MEMWB, S_BRANCH, S_JUMP, S_JAL, S_JR: w_retire = 1'b1;
            S_MEMWR:  w_retire = memReady;
            S_DECODE: w_retire = (op == OP_HALT);
            default:  w_retire = 1'b0;
        endcase
    end

    // Output decode.
    multicycle_ctrl_outdec u_outdec (
        .i_state     (r_state),
        .i_op        (op),
        .i_zero      (zero),
        .i_mem_ready (memReady),
        .o_ctrl      (w_out)
    );

    assign memReq   = w_out.mem_req;
    assign memWe    = w_out.mem_we;
    assign iOrD     = w_out.i_or_d;
    assign irWrite  = w_out.ir_write;
    assign pcWrite  = w_out.pc_write;
    assign pcSrc    = w_out.pc_src;
    assign regWrite = w_out.reg_write;
    assign regDst   = w_out.reg_dst;
    assign memToReg = w_out.mem_to_reg;
    assign aluSrcA  = w_out.alu_src_a;
    assign aluSrcB  = w_out.alu_src_b;
    assign aluCtrl  = w_out.alu_ctrl;
    assign halted   = r_halted;
    assign error    = r_error;
    assign instret  = r_instret;

endmodule
